// File: rtl/i3c_pkg.sv
// Shared types and default constants for the I3C pad-side logic.
// Bus-state encoding plus default filter and counter sizing.
package i3c_pkg;

   typedef enum logic [1:0] {
      BUSY      = 2'd0,
      FREE_WAIT = 2'd1,
      FREE      = 2'd2,
      IDLE      = 2'd3
   } bus_state_e;

   localparam int I3cSyncStages   = 2;
   localparam int I3cGlitchCycles = 3;
   localparam int I3cBusCntWidth  = 16;

endpackage

// File: rtl/i3c_glitch_filter.sv
// Per-line input conditioning: synchronizer chain followed by a
// stability counter that only accepts levels held long enough.
module i3c_glitch_filter
   import i3c_pkg::*;
#(
   parameter int SyncStages   = I3cSyncStages,
   parameter int GlitchCycles = I3cGlitchCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pad_i,
   output logic level_o
);

   localparam int CW = (GlitchCycles > 1) ? $clog2(GlitchCycles) : 1;
   localparam logic [CW-1:0] CntMax = CW'(GlitchCycles - 1);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  lvl_q, lvl_d;
   logic                  s;

   assign s      = sync_q[SyncStages-1];
   assign sync_d = {sync_q[SyncStages-2:0], pad_i};

   // Counter tracks consecutive mismatch cycles; any agreement restarts it.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s != lvl_q) begin
         if (cnt_q == CntMax) begin
            lvl_d = s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         cnt_q  <= '0;
         lvl_q  <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
      end
   end

   assign level_o = lvl_q;

endmodule

// File: rtl/i3c_bus_conditioner.sv
// Pad-side conditioner: filtered SCL/SDA, edge and START/STOP
// detection, bus free/idle tracking and registered pad drive.
module i3c_bus_conditioner
   import i3c_pkg::*;
#(
   parameter int SyncStages   = I3cSyncStages,
   parameter int GlitchCycles = I3cGlitchCycles,
   parameter int CntWidth     = I3cBusCntWidth
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                scl_pad_i,
   input  logic                sda_pad_i,
   output logic                scl_pad_o,
   output logic                sda_pad_o,
   output logic                scl_pad_oe_o,
   output logic                sda_pad_oe_o,
   input  logic                scl_core_i,
   input  logic                sda_core_i,
   input  logic                scl_oe_i,
   input  logic                sda_oe_i,
   input  logic                sel_od_pp_i,
   output logic                scl_o,
   output logic                sda_o,
   output logic                scl_rise_o,
   output logic                scl_fall_o,
   output logic                start_det_o,
   output logic                stop_det_o,
   input  logic [CntWidth-1:0] bus_free_cnt_i,
   input  logic [CntWidth-1:0] bus_idle_cnt_i,
   output logic                bus_free_o,
   output logic                bus_idle_o
);

   logic scl_f, sda_f;

   i3c_glitch_filter #(
      .SyncStages   (SyncStages),
      .GlitchCycles (GlitchCycles)
   ) u_scl_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (scl_pad_i),
      .level_o (scl_f)
   );

   i3c_glitch_filter #(
      .SyncStages   (SyncStages),
      .GlitchCycles (GlitchCycles)
   ) u_sda_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (sda_pad_i),
      .level_o (sda_f)
   );

   logic scl_prev_q, sda_prev_q;
   logic rise_q, rise_d, fall_q, fall_d;
   logic start_q, start_d, stop_q, stop_d;
   logic both_hi;

   assign rise_d  = ~scl_prev_q & scl_f;
   assign fall_d  = scl_prev_q & ~scl_f;
   // SCL must be high before and after, so a joint SCL/SDA change is ignored.
   assign start_d = scl_prev_q & scl_f & sda_prev_q & ~sda_f;
   assign stop_d  = scl_prev_q & scl_f & ~sda_prev_q & sda_f;
   assign both_hi = scl_f & sda_f;

   bus_state_e          state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start_d) begin
         state_d = BUSY;
         cnt_d   = '0;
      end else if (state_q == BUSY) begin
         if (stop_d) begin
            state_d = FREE_WAIT;
            cnt_d   = '0;
         end
      end else if (!both_hi) begin
         state_d = FREE_WAIT;
         cnt_d   = '0;
      end else begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CntWidth'(1);
         end
         case (state_q)
            FREE_WAIT: if (cnt_q >= bus_free_cnt_i) state_d = FREE;
            FREE:      if (cnt_q >= bus_idle_cnt_i) state_d = IDLE;
            default:   ;
         endcase
      end
   end

   logic scl_pad_q, scl_pad_d, sda_pad_q, sda_pad_d;
   logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;

   // Open-drain only ever pulls low; a driven 1 releases the line.
   always_comb begin
      if (sel_od_pp_i) begin
         scl_pad_d = scl_core_i;
         sda_pad_d = sda_core_i;
         scl_oe_d  = scl_oe_i;
         sda_oe_d  = sda_oe_i;
      end else begin
         scl_pad_d = 1'b0;
         sda_pad_d = 1'b0;
         scl_oe_d  = scl_oe_i & ~scl_core_i;
         sda_oe_d  = sda_oe_i & ~sda_core_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         state_q    <= FREE_WAIT;
         cnt_q      <= '0;
         scl_pad_q  <= 1'b0;
         sda_pad_q  <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scl_pad_q  <= scl_pad_d;
         sda_pad_q  <= sda_pad_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign scl_o        = scl_f;
   assign sda_o        = sda_f;
   assign scl_rise_o   = rise_q;
   assign scl_fall_o   = fall_q;
   assign start_det_o  = start_q;
   assign stop_det_o   = stop_q;
   assign bus_free_o   = (state_q == FREE) || (state_q == IDLE);
   assign bus_idle_o   = (state_q == IDLE);
   assign scl_pad_o    = scl_pad_q;
   assign sda_pad_o    = sda_pad_q;
   assign scl_pad_oe_o = scl_oe_q;
   assign sda_pad_oe_o = sda_oe_q;

endmodule
